// File: rtl/zbt_arb_pkg.sv
// Shared constants and types for the ZBT port arbiter: bus widths,
// pipeline latencies and the per-cycle slot type.
package zbt_arb_pkg;

  localparam int ZBT_ADDR_W = 19;
  localparam int ZBT_DATA_W = 36;
  localparam int ZBT_WR_LAT = 2;
  localparam int ZBT_RD_LAT = 3;

  typedef enum logic [1:0] {
    SLOT_IDLE,
    SLOT_RD,
    SLOT_WR
  } slot_t;

endpackage

// File: rtl/zbt_wr_fifo.sv
// Small synchronous FIFO buffering camera writes (address + data) ahead of
// the ZBT arbiter. A push while full is accepted only if the head pops.
module zbt_wr_fifo
  import zbt_arb_pkg::*;
#(
  parameter int WR_DEPTH = 4,
  parameter int ADDR_W   = ZBT_ADDR_W,
  parameter int DATA_W   = ZBT_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [ADDR_W-1:0] head_addr,
  output logic [DATA_W-1:0] head_data,
  output logic              empty,
  output logic              full
);

  localparam int PW = $clog2(WR_DEPTH);

  logic [PW:0]               wr_ptr_q, wr_ptr_d;
  logic [PW:0]               rd_ptr_q, rd_ptr_d;
  logic [ADDR_W+DATA_W-1:0]  store [WR_DEPTH];
  logic                      push_ok;
  logic                      pop_ok;

  // Wrap bit differs and index bits match: every slot is occupied.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                   (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  assign {head_addr, head_data} = store[rd_ptr_q[PW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) store[wr_ptr_q[PW-1:0]] <= {push_addr, push_data};
  end

endmodule

// File: rtl/zbt_port_arbiter.sv
// Shares one ZBT bank between buffered camera writes and display reads, with
// read priority and a bounded write wait. ZBT_ARB_OVF_COUNT_EN enables ovf_count.
module zbt_port_arbiter
  import zbt_arb_pkg::*;
#(
  parameter int WR_DEPTH   = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_req,
  input  logic [ZBT_ADDR_W-1:0] wr_addr,
  input  logic [ZBT_DATA_W-1:0] wr_data,
  output logic                  wr_full,
  input  logic                  rd_req,
  input  logic [ZBT_ADDR_W-1:0] rd_addr,
  output logic                  rd_grant,
  output logic [ZBT_DATA_W-1:0] rd_data,
  output logic                  rd_valid,
  output logic [ZBT_ADDR_W-1:0] mem_addr,
  output logic                  mem_we,
  output logic [ZBT_DATA_W-1:0] mem_wdata,
  input  logic [ZBT_DATA_W-1:0] mem_rdata,
  output logic [15:0]           ovf_count
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  slot_t                  slot;
  logic                   fifo_pop, fifo_empty, fifo_full, force_wr;
  logic [ZBT_ADDR_W-1:0]  head_addr;
  logic [ZBT_DATA_W-1:0]  head_data;

  logic [SW-1:0]          starve_q, starve_d;
  logic [ZBT_ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic                   mem_we_q, mem_we_d;
  logic [ZBT_DATA_W-1:0]  wpipe_q [ZBT_WR_LAT];
  logic [ZBT_DATA_W-1:0]  wpipe_d [ZBT_WR_LAT];
  logic [ZBT_DATA_W-1:0]  mem_wdata_q, mem_wdata_d;
  logic [ZBT_RD_LAT-1:0]  rpipe_q, rpipe_d;
  logic [ZBT_DATA_W-1:0]  rd_data_q, rd_data_d;
  logic                   rd_valid_q, rd_valid_d;

  zbt_wr_fifo #(
    .WR_DEPTH (WR_DEPTH),
    .ADDR_W   (ZBT_ADDR_W),
    .DATA_W   (ZBT_DATA_W)
  ) u_wr_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (wr_req),
    .push_addr (wr_addr),
    .push_data (wr_data),
    .pop       (fifo_pop),
    .head_addr (head_addr),
    .head_data (head_data),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign force_wr = (starve_q == SW'(STARVE_MAX)) && !fifo_empty;

  always_comb begin
    slot = SLOT_IDLE;
    if (force_wr)         slot = SLOT_WR;
    else if (rd_req)      slot = SLOT_RD;
    else if (!fifo_empty) slot = SLOT_WR;
  end

  assign rd_grant = (slot == SLOT_RD);
  assign fifo_pop = (slot == SLOT_WR);
  assign wr_full  = fifo_full;

  always_comb begin
    mem_addr_d = mem_addr_q;
    mem_we_d   = 1'b0;
    case (slot)
      SLOT_WR: begin
        mem_addr_d = head_addr;
        mem_we_d   = 1'b1;
      end
      SLOT_RD: mem_addr_d = rd_addr;
      default: ;
    endcase

    starve_d = starve_q;
    if (fifo_empty || fifo_pop)        starve_d = '0;
    else if (starve_q != SW'(STARVE_MAX)) starve_d = starve_q + SW'(1);

    // Stage 0 holds the last written word so mem_wdata is stable between writes.
    wpipe_d[0] = fifo_pop ? head_data : wpipe_q[0];
    for (int i = 1; i < ZBT_WR_LAT; i++) wpipe_d[i] = wpipe_q[i-1];
    mem_wdata_d = wpipe_q[ZBT_WR_LAT-1];

    rpipe_d    = {rpipe_q[ZBT_RD_LAT-2:0], rd_grant};
    rd_valid_d = rpipe_q[ZBT_RD_LAT-1];
    rd_data_d  = rpipe_q[ZBT_RD_LAT-1] ? mem_rdata : rd_data_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_q    <= '0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      for (int i = 0; i < ZBT_WR_LAT; i++) wpipe_q[i] <= '0;
      mem_wdata_q <= '0;
      rpipe_q     <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
    end else begin
      starve_q    <= starve_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      for (int i = 0; i < ZBT_WR_LAT; i++) wpipe_q[i] <= wpipe_d[i];
      mem_wdata_q <= mem_wdata_d;
      rpipe_q     <= rpipe_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_we    = mem_we_q;
  assign mem_wdata = mem_wdata_q;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;

`ifdef ZBT_ARB_OVF_COUNT_EN
  logic [15:0] ovf_q, ovf_d;
  logic        wr_drop;

  assign wr_drop = wr_req && fifo_full && !fifo_pop;

  always_comb begin
    ovf_d = ovf_q;
    if (wr_drop && (ovf_q != 16'hFFFF)) ovf_d = ovf_q + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ovf_q <= '0;
    else       ovf_q <= ovf_d;
  end

  assign ovf_count = ovf_q;
`else
  assign ovf_count = '0;
`endif

endmodule

// File: tb/tb_zbt_port_arbiter.sv
// Directed bench for zbt_port_arbiter: stimulus queues expected writes/reads,
// a negedge monitor pops and compares them as mem_we / rd_valid appear.
module tb_zbt_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_req;
  logic [18:0] wr_addr;
  logic [35:0] wr_data;
  logic        wr_full;
  logic        rd_req;
  logic [18:0] rd_addr;
  logic        rd_grant;
  logic [35:0] rd_data;
  logic        rd_valid;
  logic [18:0] mem_addr;
  logic        mem_we;
  logic [35:0] mem_wdata;
  logic [35:0] mem_rdata;
  logic [15:0] ovf_count;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;

  typedef struct { logic [18:0] addr; logic [35:0] data; } wr_t;
  typedef struct { int due; logic [35:0] data; } pend_t;

  wr_t         exp_wr_q [$];
  logic [35:0] exp_rd_q [$];
  pend_t       wd_pend_q [$];
  int          grant_cyc_q [$];

`ifdef ZBT_ARB_OVF_COUNT_EN
  localparam logic [15:0] EXP_OVF = 16'd2;
`else
  localparam logic [15:0] EXP_OVF = 16'd0;
`endif

  zbt_port_arbiter #(.WR_DEPTH(4), .STARVE_MAX(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .wr_req    (wr_req),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_full   (wr_full),
    .rd_req    (rd_req),
    .rd_addr   (rd_addr),
    .rd_grant  (rd_grant),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .ovf_count (ovf_count)
  );

  always #5 clk = ~clk;

  function automatic logic [35:0] rdfun(input logic [18:0] a);
    if (a == 19'h00100) return 36'h0_12345678;
    return {a, 17'h0A5A5};
  endfunction

  // ZBT model: address at edge N, data driven on the bus from N+2 to N+3.
  logic [18:0] a1;
  always @(posedge clk) begin
    a1        <= mem_addr;
    mem_rdata <= rdfun(a1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      grant_cyc_q.delete();
      wd_pend_q.delete();
    end else begin
      if (rd_grant) grant_cyc_q.push_back(cyc);
      if (wd_pend_q.size() > 0 && wd_pend_q[0].due == cyc) begin
        pend_t p;
        p = wd_pend_q.pop_front();
        chk("mon_wdata", 64'(mem_wdata), 64'(p.data));
        $display("wr  data=%h", mem_wdata);
      end
      if (mem_we) begin
        if (exp_wr_q.size() == 0) begin
          chk("mon_wr_unexpected", 64'(mem_addr), 64'h1_0000_0000);
        end else begin
          wr_t e;
          pend_t p;
          e = exp_wr_q.pop_front();
          chk("mon_wr_addr", 64'(mem_addr), 64'(e.addr));
          p.due  = cyc + 2;
          p.data = e.data;
          wd_pend_q.push_back(p);
          $display("wr  addr=%h", mem_addr);
        end
      end
      if (rd_valid) begin
        if (exp_rd_q.size() == 0) begin
          chk("mon_rd_unexpected", 64'(rd_data), 64'h1_0000_0000_0);
        end else begin
          logic [35:0] e;
          e = exp_rd_q.pop_front();
          chk("mon_rd_data", 64'(rd_data), 64'(e));
        end
        if (grant_cyc_q.size() == 0) begin
          chk("mon_rd_latency_nogrant", 64'd0, 64'd4);
        end else begin
          int g;
          g = grant_cyc_q.pop_front();
          // Grant is seen at the negedge before the grant edge, hence 3+1.
          chk("mon_rd_latency", 64'(cyc - g), 64'd4);
        end
        $display("rd  data=%h", rd_data);
      end
    end
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_mem_addr"},  64'(mem_addr),  64'd0);
    chk({tag, "_mem_we"},    64'(mem_we),    64'd0);
    chk({tag, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
    chk({tag, "_rd_data"},   64'(rd_data),   64'd0);
    chk({tag, "_rd_valid"},  64'(rd_valid),  64'd0);
    chk({tag, "_ovf"},       64'(ovf_count), 64'd0);
    chk({tag, "_wr_full"},   64'(wr_full),   64'd0);
  endtask

  initial begin
    wr_t w;
    logic exp_g;
    reset = 1'b1; wr_req = 0; wr_addr = '0; wr_data = '0; rd_req = 0; rd_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("rst");
    chk("rst_rd_grant", 64'(rd_grant), 64'd0);
    reset = 1'b0;
    tick();

    // Single write
    wr_req = 1; wr_addr = 19'h00010; wr_data = 36'h0_DEADBEEF;
    w.addr = wr_addr; w.data = wr_data; exp_wr_q.push_back(w);
    tick();
    wr_req = 0;
    chk("t1_we_push_edge", 64'(mem_we), 64'd0);
    tick();
    chk("t1_we", 64'(mem_we), 64'd1);
    chk("t1_addr", 64'(mem_addr), 64'h10);
    tick();
    chk("t1_we_off", 64'(mem_we), 64'd0);
    chk("t1_wdata_early", 64'(mem_wdata), 64'd0);
    tick();
    chk("t1_wdata", 64'(mem_wdata), 64'h0_DEADBEEF);
    repeat (2) tick();

    // Single read
    rd_req = 1; rd_addr = 19'h00100;
    #1;
    chk("t2_grant", 64'(rd_grant), 64'd1);
    exp_rd_q.push_back(36'h0_12345678);
    tick();
    rd_req = 0;
    tick(); tick();
    chk("t2_valid_early", 64'(rd_valid), 64'd0);
    tick();
    chk("t2_valid", 64'(rd_valid), 64'd1);
    chk("t2_data", 64'(rd_data), 64'h0_12345678);
    tick();
    chk("t2_valid_pulse", 64'(rd_valid), 64'd0);
    repeat (2) tick();

    // Starvation: one queued write behind continuous reads
    for (int i = 0; i <= 10; i++) begin
      rd_req = 1; rd_addr = 19'h00200 + 19'(i);
      wr_req = (i == 0); wr_addr = 19'h00020; wr_data = 36'h1_00000020;
      if (i == 0) begin w.addr = wr_addr; w.data = wr_data; exp_wr_q.push_back(w); end
      #1;
      exp_g = (i != 9);
      chk($sformatf("t3_grant_%0d", i), 64'(rd_grant), 64'(exp_g));
      if (exp_g) exp_rd_q.push_back(rdfun(rd_addr));
      tick();
      if (i == 9) begin
        chk("t3_forced_we", 64'(mem_we), 64'd1);
        chk("t3_forced_addr", 64'(mem_addr), 64'h20);
      end
    end
    rd_req = 0; wr_req = 0;
    repeat (6) tick();

    // Overflow, then push while full during the forced write slot
    for (int i = 0; i <= 9; i++) begin
      rd_req = 1; rd_addr = 19'h00400 + 19'(i);
      wr_req = (i < 6) || (i == 9);
      wr_addr = 19'h00040 + 19'(i); wr_data = 36'hA_0000_0000 | 36'(i);
      if (i < 4 || i == 9) begin w.addr = wr_addr; w.data = wr_data; exp_wr_q.push_back(w); end
      #1;
      exp_g = (i != 9);
      chk($sformatf("t4_grant_%0d", i), 64'(rd_grant), 64'(exp_g));
      if (exp_g) exp_rd_q.push_back(rdfun(rd_addr));
      tick();
      if (i == 2) chk("t4_not_full_3", 64'(wr_full), 64'd0);
      if (i == 3) chk("t4_full_4", 64'(wr_full), 64'd1);
      if (i == 5) chk("t4_ovf", 64'(ovf_count), 64'(EXP_OVF));
      if (i == 9) begin
        chk("t5_full_kept", 64'(wr_full), 64'd1);
        chk("t5_ovf_kept", 64'(ovf_count), 64'(EXP_OVF));
        chk("t5_forced_we", 64'(mem_we), 64'd1);
        chk("t5_forced_addr", 64'(mem_addr), 64'h40);
      end
    end
    rd_req = 0; wr_req = 0;
    repeat (8) tick();
    chk("t5_drained", 64'(wr_full), 64'd0);

    // Reset one cycle after a read grant
    rd_req = 1; rd_addr = 19'h00300;
    #1;
    chk("t6_grant", 64'(rd_grant), 64'd1);
    tick();
    rd_req = 0;
    tick();
    reset = 1'b1;
    #1;
    chk_reset_vals("t6_in_rst");
    tick();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("t6_no_valid_%0d", i), 64'(rd_valid), 64'd0);
      chk($sformatf("t6_no_we_%0d", i), 64'(mem_we), 64'd0);
    end
    chk_reset_vals("t6_after");

    chk("end_wr_q_empty", 64'(exp_wr_q.size()), 64'd0);
    chk("end_rd_q_empty", 64'(exp_rd_q.size()), 64'd0);
    chk("end_wd_pend_empty", 64'(wd_pend_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/zbt_port_arbiter.md
# zbt_port_arbiter

- Shares one ZBT SRAM bank between two requesters:
  - the camera write stream (one-cycle write strobes from the NTSC capture path);
  - the display read stream (pixel fetches from the VGA display engine).
- Buffers camera writes in a small FIFO, grants the display reads priority, and bounds write starvation.
- Drives the pipelined ZBT address/write-enable/data timing: write data two cycles after address, read data returned three cycles after grant.
- Sits between the capture/display blocks and the ZBT pin driver in the labkit top level.

## Interface
- WR_DEPTH, 4 — write FIFO entries (power of two, ≥2).
- STARVE_MAX, 8 — max consecutive cycles a non-empty FIFO may wait before a write slot is forced.
- clk  in  1  system clock (ZBT clock domain).
- reset  in  1  asynchronous, active-high reset.
- wr_req  in  1  write strobe from capture path.
- wr_addr  in  19  write word address.
- wr_data  in  36  write word.
- wr_full  out  1  FIFO full (informational; capture path does not stall).
- rd_req  in  1  display read request.
- rd_addr  in  19  read word address.
- rd_grant  out  1  combinational; read accepted this cycle.
- rd_data  out  36  returned read word.
- rd_valid  out  1  one-cycle pulse, rd_data valid.
- mem_addr  out  19  ZBT address.
- mem_we  out  1  ZBT write enable, active-high (pin driver inverts).
- mem_wdata  out  36  ZBT write data.
- mem_rdata  in  36  ZBT read data bus.
- ovf_count  out  16  dropped-write count (see Configuration).

## Operation
- Slot decision each cycle, in priority order:
  - force_wr (starve counter == STARVE_MAX and FIFO non-empty) → write slot;
  - else rd_req → read slot; rd_grant = 1;
  - else FIFO non-empty → write slot;
  - else idle: mem_we = 0, mem_addr holds.
- Write slot: pop FIFO head; mem_addr ← head addr; mem_we ← 1.
- Read slot: mem_addr ← rd_addr; mem_we ← 0.
- Starve counter:
  - increments each cycle the FIFO is non-empty and no write slot is granted;
  - clears on any write slot or when the FIFO is empty;
  - saturates at STARVE_MAX.
- FIFO push on wr_req:
  - accepted if not full, or if full and popped in the same cycle;
  - otherwise the write is dropped and the FIFO is unchanged.
- Simultaneous push and pop on an empty FIFO: no bypass; the pushed entry is stored and granted no earlier than the next cycle.
- Pointer arithmetic: log2(WR_DEPTH) bits plus one wrap bit; full/empty are decoded from the wrap bit.

## Timing
- Reset values: mem_addr = 0, mem_we = 0, mem_wdata = 0, rd_data = 0, rd_valid = 0, ovf_count = 0, FIFO empty, starve counter 0. rd_grant and wr_full then follow from empty state.
- Grant at edge N:
  - mem_addr and mem_we update at N;
  - write: mem_wdata valid from edge N+2 to N+3 (2-stage data pipe);
  - read: mem_rdata sampled at edge N+3; rd_data and rd_valid registered at N+3.
- Read latency is a fixed 3 cycles, grant to rd_valid. Back-to-back reads give back-to-back rd_valid pulses.
- Reset mid-operation clears all in-flight pipe stages; no stale rd_valid or mem_we after reset deasserts.

## Configuration
- ZBT_ARB_OVF_COUNT_EN defined:
  - ovf_count increments by 1 on each dropped write;
  - saturates at 16'hFFFF;
  - cleared only by reset.
- Undefined: ovf_count tied to 0 and no counter logic.

## Structure
- Shared package zbt_arb_pkg holds:
  - ZBT_ADDR_W = 19, ZBT_DATA_W = 36, ZBT_WR_LAT = 2, ZBT_RD_LAT = 3;
  - the slot-type enum {SLOT_IDLE, SLOT_RD, SLOT_WR}.
- Sub-module zbt_wr_fifo (synchronous FIFO, parameter WR_DEPTH) holds the write path. Arbitration, starvation logic and data/valid pipes live in the top module.

## Test plan
- Single write: wr_req, addr 19'h00010, data 36'h0_DEADBEEF on an idle arbiter → mem_we = 1 with mem_addr 19'h00010 one cycle later; mem_wdata = 36'h0_DEADBEEF two cycles after that.
- Single read: rd_req, addr 19'h00100; memory model returns 36'h0_12345678 → rd_grant = 1 the same cycle; rd_valid with that data exactly 3 cycles later.
- Starvation: continuous rd_req with one queued write → rd_grant drops for exactly one cycle after 8 waiting cycles; write issued in that slot.
- Overflow: continuous rd_req, STARVE_MAX = 8, 6 consecutive wr_req → wr_full after 4 pushes; 2 writes dropped; ovf_count = 2 with ZBT_ARB_OVF_COUNT_EN, 0 without.
- Full push+pop: FIFO full with forced write slot, wr_req same cycle → push accepted, occupancy stays 4, no drop counted.
- Reset mid-read: assert reset one cycle after a read grant → no rd_valid afterwards; all outputs at reset values.
